// File: rtl/fetch_realign_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fetch_realign_pkg
// Purpose  : Shared types and helpers for the halfword fetch realignment block.
//            parcel_t      - one 16-bit instruction parcel
//            OPC_FULL      - low opcode bits that mark a 32-bit instruction
//            is_compressed - 1 when a parcel is a complete 16-bit instruction
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package fetch_realign_pkg;

    typedef logic [15:0] parcel_t;

    localparam logic [1:0] OPC_FULL = 2'b11;

    function automatic logic is_compressed(input parcel_t p);
        return (p[1:0] != OPC_FULL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_realign_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fetch_realign_if
// Purpose  : Handshake bundle around the fetch realignment buffer.
//            Fetch side : word_valid/word_ready/word_data
//            Redirect   : flush/redirect_pc
//            Decode side: instr_valid/instr_ready/instr_data/instr_is_c/instr_pc
//            Perf       : cnt_c/cnt_full
//            master = fetch/decode environment, slave = realignment buffer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface fetch_realign_if;

    logic        word_valid;
    logic        word_ready;
    logic [31:0] word_data;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic        instr_is_c;
    logic [31:0] instr_pc;
    logic [31:0] cnt_c;
    logic [31:0] cnt_full;

    modport master (
        output word_valid, word_data, flush, redirect_pc, instr_ready,
        input  word_ready, instr_valid, instr_data, instr_is_c, instr_pc,
               cnt_c, cnt_full
    );

    modport slave (
        input  word_valid, word_data, flush, redirect_pc, instr_ready,
        output word_ready, instr_valid, instr_data, instr_is_c, instr_pc,
               cnt_c, cnt_full
    );

endinterface
`default_nettype wire

// File: rtl/fetch_realign_hq_fifo.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fetch_realign_hq_fifo
// Purpose  : Halfword queue with a 2-wide push and a 1/2-wide pop.
//            clk, reset          - clock, synchronous active-high reset
//            clear               - empties the queue (redirect)
//            push_cnt, push_d0/1 - number of parcels written (0..2), d0 first
//            pop_cnt             - number of parcels removed (0..2)
//            head0, head1        - oldest and second-oldest parcels
//            count               - registered occupancy
//            Caller guarantees no overflow and no underflow.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module fetch_realign_hq_fifo
    import fetch_realign_pkg::*;
#(
    parameter int HQ_DEPTH = 4
) (
    input  wire logic                      clk,
    input  wire logic                      reset,
    input  wire logic                      clear,
    input  wire logic [1:0]                push_cnt,
    input  wire parcel_t                   push_d0,
    input  wire parcel_t                   push_d1,
    input  wire logic [1:0]                pop_cnt,
    output parcel_t                        head0,
    output parcel_t                        head1,
    output logic [$clog2(HQ_DEPTH):0]      count
);

    localparam int AW = $clog2(HQ_DEPTH);
    localparam int CW = AW + 1;

    parcel_t           r_mem [HQ_DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic [AW-1:0]     w_wptr_p1;
    logic [AW-1:0]     w_rptr_p1;

    assign w_wptr_p1 = r_wptr + AW'(1);
    assign w_rptr_p1 = r_rptr + AW'(1);

    assign head0 = r_mem[r_rptr];
    assign head1 = r_mem[w_rptr_p1];
    assign count = r_count;

    // Pointers wrap naturally because HQ_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + AW'(push_cnt);
            r_rptr  <= r_rptr + AW'(pop_cnt);
            r_count <= r_count + CW'(push_cnt) - CW'(pop_cnt);
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (!clear) begin
            if (push_cnt != 2'd0) r_mem[r_wptr]    <= push_d0;
            if (push_cnt == 2'd2) r_mem[w_wptr_p1] <= push_d1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_realign.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fetch_realign
// Purpose  : Halfword realignment buffer between instruction fetch and the
//            RVC decompressor. Takes aligned 32-bit fetch words and emits one
//            instruction per handshake (16-bit parcel or 32-bit instruction,
//            including ones straddling two words), with its PC.
//            clk, reset  - clock, synchronous active-high reset
//            bus (slave) - fetch handshake, redirect, decode handshake, perf
// Config   : FETCH_PERF_CNT_EN - when defined, cnt_c/cnt_full count emitted
//            compressed / 32-bit instructions; otherwise both are tied to 0.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module fetch_realign
    import fetch_realign_pkg::*;
#(
    parameter int          HQ_DEPTH = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic      clk,
    input  wire logic      reset,
    fetch_realign_if.slave bus
);

    localparam int CW = $clog2(HQ_DEPTH) + 1;
    // Two free entries are needed for a full word; judged on the registered
    // count so a same-cycle pop never grants extra credit.
    localparam logic [CW-1:0] c_ready_max = CW'(HQ_DEPTH - 2);

    logic [CW-1:0] w_count;
    parcel_t       w_head0;
    parcel_t       w_head1;
    logic          w_head_c;
    logic          w_instr_valid;
    logic          w_word_ready;
    logic          w_accept;
    logic          w_pop;
    logic [1:0]    w_push_cnt;
    logic [1:0]    w_pop_cnt;
    parcel_t       w_push_d0;
    logic [31:0]   r_head_pc;
    logic          r_drop_low;
    logic          w_unused;

    fetch_realign_hq_fifo #(
        .HQ_DEPTH (HQ_DEPTH)
    ) u_hq (
        .clk      (clk),
        .reset    (reset),
        .clear    (bus.flush),
        .push_cnt (w_push_cnt),
        .push_d0  (w_push_d0),
        .push_d1  (bus.word_data[31:16]),
        .pop_cnt  (w_pop_cnt),
        .head0    (w_head0),
        .head1    (w_head1),
        .count    (w_count)
    );

    assign w_head_c = is_compressed(w_head0);

    // A 32-bit instruction needs both halves present; a lone upper half waits.
    assign w_instr_valid = !bus.flush &&
                           (w_head_c ? (w_count >= CW'(1)) : (w_count >= CW'(2)));
    assign w_word_ready  = !bus.flush && (w_count <= c_ready_max);
    assign w_accept      = bus.word_valid && w_word_ready;
    assign w_pop         = w_instr_valid && bus.instr_ready;

    // After a redirect to an odd halfword the low half of the first word
    // precedes the target and is discarded.
    assign w_push_cnt = !w_accept ? 2'd0 : (r_drop_low ? 2'd1 : 2'd2);
    assign w_push_d0  = r_drop_low ? bus.word_data[31:16] : bus.word_data[15:0];
    assign w_pop_cnt  = !w_pop ? 2'd0 : (w_head_c ? 2'd1 : 2'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head_pc  <= RESET_PC;
            r_drop_low <= RESET_PC[1];
        end else if (bus.flush) begin
            r_head_pc  <= {bus.redirect_pc[31:1], 1'b0};
            r_drop_low <= bus.redirect_pc[1];
        end else begin
            if (w_pop)    r_head_pc  <= r_head_pc + (w_head_c ? 32'd2 : 32'd4);
            if (w_accept) r_drop_low <= 1'b0;
        end
    end

    assign bus.word_ready  = w_word_ready;
    assign bus.instr_valid = w_instr_valid;
    assign bus.instr_is_c  = w_instr_valid && w_head_c;
    assign bus.instr_pc    = r_head_pc;
    assign bus.instr_data  = !w_instr_valid ? 32'd0 :
                             (w_head_c ? {16'd0, w_head0} : {w_head1, w_head0});

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_cnt_c;
    logic [31:0] r_cnt_full;

    // Counters survive a redirect; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_c    <= '0;
            r_cnt_full <= '0;
        end else if (w_pop) begin
            if (w_head_c) r_cnt_c    <= r_cnt_c + 32'd1;
            else          r_cnt_full <= r_cnt_full + 32'd1;
        end
    end

    assign bus.cnt_c    = r_cnt_c;
    assign bus.cnt_full = r_cnt_full;
`else
    assign bus.cnt_c    = 32'd0;
    assign bus.cnt_full = 32'd0;
`endif

    // Bit 0 of the redirect target is meaningless for halfword-aligned PCs.
    assign w_unused = bus.redirect_pc[0];

endmodule
`default_nettype wire

// File: tb/tb_fetch_realign.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_fetch_realign
// Purpose  : Self-checking bench for fetch_realign. Table of fetch words with
//            the instructions each one completes, plus hand-written stall and
//            flush sequences. Expected instructions go into a queue and are
//            compared as the DUT hands them to decode.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_fetch_realign;

    typedef struct packed {
        logic [31:0] d;
        logic [31:0] pc;
        logic        c;
    } exp_t;

    typedef struct {
        int          grp;
        bit          rst;
        bit          fl;
        logic [31:0] redir;
        logic [31:0] word;
        int          n;
        exp_t        e0;
        exp_t        e1;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    fetch_realign_if ifc ();

    fetch_realign #(
        .HQ_DEPTH (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_err = 0;
    int   exp_c = 0;
    int   exp_full = 0;
    exp_t q[$];
    vec_t vecs[10];
    logic drv_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_cnt(input string tag);
`ifdef FETCH_PERF_CNT_EN
        chk({tag, ".cnt_c"},    ifc.cnt_c,    exp_c);
        chk({tag, ".cnt_full"}, ifc.cnt_full, exp_full);
`else
        chk({tag, ".cnt_c"},    ifc.cnt_c,    32'd0);
        chk({tag, ".cnt_full"}, ifc.cnt_full, 32'd0);
`endif
    endtask

    // Scoreboard: a handshake seen at negedge pops at the following posedge.
    always @(negedge clk) begin
        if (!reset && ifc.instr_valid && ifc.instr_ready) begin
            if (q.size() == 0) begin
                chk("pop.unexpected", ifc.instr_pc, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pop.data", ifc.instr_data, e.d);
                chk("pop.pc",   ifc.instr_pc,   e.pc);
                chk("pop.is_c", {31'd0, ifc.instr_is_c}, {31'd0, e.c});
                if (e.c) exp_c++;
                else     exp_full++;
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        ifc.word_valid = 1'b0;
        ifc.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        exp_c = 0;
        exp_full = 0;
    endtask

    task automatic do_flush(input logic [31:0] pc);
        ifc.flush = 1'b1;
        ifc.redirect_pc = pc;
        @(posedge clk);
        #1;
        ifc.flush = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        bit ok;
        ok = 0;
        ifc.word_valid = 1'b1;
        ifc.word_data = w;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (ifc.word_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
            end
        end
        ifc.word_valid = 1'b0;
        chk("send.accepted", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        chk({tag, ".drained"}, q.size(), 32'd0);
    endtask

    initial begin
        vecs[0] = '{grp:1, rst:1, fl:0, redir:32'h0, word:32'h0001_4501, n:2,
                    e0:'{d:32'h0000_4501, pc:32'h0, c:1'b1},
                    e1:'{d:32'h0000_0001, pc:32'h2, c:1'b1}};
        vecs[1] = '{grp:2, rst:0, fl:1, redir:32'h0, word:32'h0513_0001, n:1,
                    e0:'{d:32'h0000_0001, pc:32'h0, c:1'b1},
                    e1:'{d:32'h0, pc:32'h0, c:1'b0}};
        vecs[2] = '{grp:2, rst:0, fl:0, redir:32'h0, word:32'h4501_0000, n:2,
                    e0:'{d:32'h0000_0513, pc:32'h2, c:1'b0},
                    e1:'{d:32'h0000_4501, pc:32'h6, c:1'b1}};
        vecs[3] = '{grp:3, rst:0, fl:1, redir:32'h0000_0102, word:32'h4501_1111, n:1,
                    e0:'{d:32'h0000_4501, pc:32'h102, c:1'b1},
                    e1:'{d:32'h0, pc:32'h0, c:1'b0}};
        vecs[4] = '{grp:3, rst:0, fl:0, redir:32'h0, word:32'h0000_0001, n:2,
                    e0:'{d:32'h0000_0001, pc:32'h104, c:1'b1},
                    e1:'{d:32'h0000_0000, pc:32'h106, c:1'b1}};
        vecs[5] = '{grp:6, rst:1, fl:1, redir:32'h0000_0002, word:32'h0001_7777, n:1,
                    e0:'{d:32'h0000_0001, pc:32'h2, c:1'b1},
                    e1:'{d:32'h0, pc:32'h0, c:1'b0}};
        vecs[6] = '{grp:6, rst:0, fl:0, redir:32'h0, word:32'h0000_0513, n:1,
                    e0:'{d:32'h0000_0513, pc:32'h4, c:1'b0},
                    e1:'{d:32'h0, pc:32'h0, c:1'b0}};
        vecs[7] = '{grp:6, rst:0, fl:0, redir:32'h0, word:32'h00A0_0593, n:1,
                    e0:'{d:32'h00A0_0593, pc:32'h8, c:1'b0},
                    e1:'{d:32'h0, pc:32'h0, c:1'b0}};
        vecs[8] = '{grp:6, rst:0, fl:0, redir:32'h0, word:32'h4505_4501, n:2,
                    e0:'{d:32'h0000_4501, pc:32'hC, c:1'b1},
                    e1:'{d:32'h0000_4505, pc:32'hE, c:1'b1}};
        vecs[9] = '{grp:0, rst:0, fl:0, redir:32'h0, word:32'h0, n:0,
                    e0:'{d:32'h0, pc:32'h0, c:1'b0},
                    e1:'{d:32'h0, pc:32'h0, c:1'b0}};

        ifc.word_valid  = 1'b0;
        ifc.word_data   = 32'd0;
        ifc.flush       = 1'b0;
        ifc.redirect_pc = 32'd0;
        ifc.instr_ready = 1'b1;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst.word_ready",  {31'd0, ifc.word_ready},  32'd1);
        chk("rst.instr_valid", {31'd0, ifc.instr_valid}, 32'd0);
        chk("rst.instr_data",  ifc.instr_data,           32'd0);
        chk("rst.instr_is_c",  {31'd0, ifc.instr_is_c},  32'd0);
        chk("rst.instr_pc",    ifc.instr_pc,             32'd0);
        chk_cnt("rst");
        @(posedge clk);
        #1;

        // Stall with four words offered: queue fills, outputs hold, then drains
        ifc.instr_ready = 1'b0;
        do_flush(32'h0000_0200);
        for (int i = 0; i < 8; i++)
            q.push_back('{d:32'h4501 + 32'(4 * i), pc:32'h200 + 32'(2 * i), c:1'b1});
        drv_done = 1'b0;
        fork
            begin
                send_word(32'h4505_4501);
                send_word(32'h450D_4509);
                send_word(32'h4515_4511);
                send_word(32'h451D_4519);
                drv_done = 1'b1;
            end
        join_none
        repeat (6) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall.word_ready",  {31'd0, ifc.word_ready},  32'd0);
            chk("stall.instr_valid", {31'd0, ifc.instr_valid}, 32'd1);
            chk("stall.instr_data",  ifc.instr_data,           32'h0000_4501);
            chk("stall.instr_pc",    ifc.instr_pc,             32'h0000_0200);
            chk("stall.instr_is_c",  {31'd0, ifc.instr_is_c},  32'd1);
        end
        @(posedge clk);
        #1;
        ifc.instr_ready = 1'b1;
        for (int i = 0; i < 100 && !drv_done; i++) @(posedge clk);
        #1;
        chk("stall.driver_done", {31'd0, drv_done}, 32'd1);
        wait_drain("stall");

        // Flush colliding with a push and a pop
        ifc.instr_ready = 1'b0;
        do_flush(32'h0000_0300);
        send_word(32'h0001_4501);
        ifc.flush = 1'b1;
        ifc.redirect_pc = 32'h0000_0400;
        ifc.word_valid = 1'b1;
        ifc.word_data = 32'h4509_4505;
        ifc.instr_ready = 1'b1;
        @(negedge clk);
        chk("flush.word_ready",  {31'd0, ifc.word_ready},  32'd0);
        chk("flush.instr_valid", {31'd0, ifc.instr_valid}, 32'd0);
        @(posedge clk);
        #1;
        ifc.flush = 1'b0;
        ifc.word_valid = 1'b0;
        @(negedge clk);
        chk("flush.after_valid", {31'd0, ifc.instr_valid}, 32'd0);
        chk("flush.after_ready", {31'd0, ifc.word_ready},  32'd1);
        chk("flush.after_pc",    ifc.instr_pc,             32'h0000_0400);
        chk_cnt("flush");
        @(posedge clk);
        #1;
        q.push_back('{d:32'h0000_4501, pc:32'h400, c:1'b1});
        q.push_back('{d:32'h0000_0001, pc:32'h402, c:1'b1});
        send_word(32'h0001_4501);
        wait_drain("flush");

        // Table-driven groups
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].grp == 0) break;
            if (i == 0 || vecs[i].grp != vecs[i-1].grp) begin
                if (i != 0) wait_drain("grp");
                if (vecs[i].rst) do_reset();
                if (vecs[i].fl)  do_flush(vecs[i].redir);
            end
            if (vecs[i].n >= 1) q.push_back(vecs[i].e0);
            if (vecs[i].n >= 2) q.push_back(vecs[i].e1);
            send_word(vecs[i].word);
        end
        wait_drain("grp");

        // Perf counters after 3 compressed + 2 full since the last reset
        @(negedge clk);
`ifdef FETCH_PERF_CNT_EN
        chk("perf.cnt_c",    ifc.cnt_c,    32'd3);
        chk("perf.cnt_full", ifc.cnt_full, 32'd2);
`else
        chk("perf.cnt_c",    ifc.cnt_c,    32'd0);
        chk("perf.cnt_full", ifc.cnt_full, 32'd0);
`endif
        chk("end.instr_valid", {31'd0, ifc.instr_valid}, 32'd0);
        chk("end.instr_pc",    ifc.instr_pc,             32'h0000_0010);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
